elevator_scheduler: RTL and testbench

//  Call scheduler that drives elevator_fsm. Latches floor call requests and issues

---
 rtl/elevator_pkg.sv | 16 +
 rtl/elevator_call_reg.sv | 53 +++++
 rtl/elevator_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types for the elevator call scheduler: FSM state encoding and scan
// direction constants.
package elevator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MOVE_CMD  = 3'd1,
        ST_MOVE_WAIT = 3'd2,
        ST_DOOR_OPEN = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_call_reg.sv
// Latched floor-call register. Holds unserved calls and reports whether any
// call lies above, below or at the floor currently presented.
module elevator_call_reg #(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] set_i,
    input  logic [NUM_FLOORS-1:0] clr_i,
    input  logic [FLOOR_W-1:0]    floor_i,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  above_o,
    output logic                  below_o,
    output logic                  here_o
);

    logic [NUM_FLOORS-1:0] pending_q;
    logic [NUM_FLOORS-1:0] pending_d;

    // Clear beats set so a call being served at this edge is not re-latched.
    always_comb begin
        pending_d = (pending_q | set_i) & ~clr_i;
    end

    // Pending call storage.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q <= {NUM_FLOORS{1'b0}};
        end else begin
            pending_q <= pending_d;
        end
    end

    // Position flags relative to floor_i; an out-of-range floor has no "here" call.
    always_comb begin
        above_o = 1'b0;
        below_o = 1'b0;
        here_o  = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(floor_i)) begin
                above_o = above_o | pending_q[i];
            end else if (i < int'(floor_i)) begin
                below_o = below_o | pending_q[i];
            end else begin
                here_o  = here_o | pending_q[i];
            end
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN call scheduler for elevator_fsm: latches calls, issues one-cycle step
// pulses, holds the door at served floors and flags a sticky move timeout.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = 4,
    parameter int FLOOR_W      = 2,
    parameter int DOOR_CYCLES  = 4,
    parameter int MOVE_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic [FLOOR_W-1:0]    floor,
    output logic                  up,
    output logic                  down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir,
    output logic                  busy,
    output logic                  fault
);

    localparam int DCW = $clog2(DOOR_CYCLES + 1);
    localparam int TCW = $clog2(MOVE_TIMEOUT + 1);

    state_e               state_q, state_d;
    logic                 dir_q, dir_d;
    logic                 up_q, up_d;
    logic                 down_q, down_d;
    logic                 door_q;
    logic                 busy_q;
    logic                 fault_q;
    logic [FLOOR_W-1:0]   target_q, target_d;
    logic [DCW-1:0]       door_cnt_q, door_cnt_d;
    logic [TCW-1:0]       tmo_q, tmo_d;

    logic [NUM_FLOORS-1:0] floor_hot_s;
    logic [NUM_FLOORS-1:0] set_s;
    logic [NUM_FLOORS-1:0] clr_s;
    logic [NUM_FLOORS-1:0] pending_s;
    logic                  above_s, below_s, here_s;
    logic                  req_here_s;
    logic                  at_top_s, at_bot_s;
    logic                  go_up_s, go_down_s, dir_pick_s;

    elevator_call_reg #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_call_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .set_i     (set_s),
        .clr_i     (clr_s),
        .floor_i   (floor),
        .pending_o (pending_s),
        .above_o   (above_s),
        .below_o   (below_s),
        .here_o    (here_s)
    );

    // One-hot decode of the current floor and the live call at that floor.
    always_comb begin
        floor_hot_s = {NUM_FLOORS{1'b0}};
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i == int'(floor)) begin
                floor_hot_s[i] = 1'b1;
            end else begin
                floor_hot_s[i] = 1'b0;
            end
        end
        req_here_s = |(req & floor_hot_s);
        at_top_s   = (floor == FLOOR_W'(NUM_FLOORS - 1));
        at_bot_s   = (floor == {FLOOR_W{1'b0}});
    end

    // SCAN choice: keep the current direction while calls remain that way.
    always_comb begin
        go_up_s    = 1'b0;
        go_down_s  = 1'b0;
        dir_pick_s = dir_q;
        if (dir_q == DIR_UP) begin
            if (above_s && !at_top_s) begin
                go_up_s = 1'b1;
            end else if (below_s && !at_bot_s) begin
                go_down_s  = 1'b1;
                dir_pick_s = DIR_DOWN;
            end else begin
                dir_pick_s = dir_q;
            end
        end else begin
            if (below_s && !at_bot_s) begin
                go_down_s = 1'b1;
            end else if (above_s && !at_top_s) begin
                go_up_s    = 1'b1;
                dir_pick_s = DIR_UP;
            end else begin
                dir_pick_s = dir_q;
            end
        end
    end

    // Next-state, counters and call set/clear control.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        up_d       = 1'b0;
        down_d     = 1'b0;
        target_d   = target_q;
        door_cnt_d = door_cnt_q;
        tmo_d      = tmo_q;
        clr_s      = {NUM_FLOORS{1'b0}};
        set_s      = req;
        case (state_q)
            ST_IDLE, ST_MOVE_WAIT: begin
                if ((state_q == ST_MOVE_WAIT) && (floor != target_q)) begin
                    if (tmo_q == TCW'(MOVE_TIMEOUT - 1)) begin
                        state_d = ST_FAULT;
                    end else begin
                        tmo_d = tmo_q + TCW'(1);
                    end
                end else if (here_s) begin
                    state_d    = ST_DOOR_OPEN;
                    door_cnt_d = {DCW{1'b0}};
                    clr_s      = floor_hot_s;
                end else if (go_up_s || go_down_s) begin
                    state_d = ST_MOVE_CMD;
                    up_d    = go_up_s;
                    down_d  = go_down_s;
                    dir_d   = dir_pick_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MOVE_CMD: begin
                if (up_q) begin
                    target_d = floor + FLOOR_W'(1);
                end else begin
                    target_d = floor - FLOOR_W'(1);
                end
                tmo_d   = {TCW{1'b0}};
                state_d = ST_MOVE_WAIT;
            end
            ST_DOOR_OPEN: begin
                // A repeat call here keeps the door open instead of queueing.
                set_s = req & ~floor_hot_s;
                if (req_here_s) begin
                    door_cnt_d = {DCW{1'b0}};
                end else if (door_cnt_q == DCW'(DOOR_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    door_cnt_d = door_cnt_q + DCW'(1);
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_UP;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            door_q     <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            target_q   <= {FLOOR_W{1'b0}};
            door_cnt_q <= {DCW{1'b0}};
            tmo_q      <= {TCW{1'b0}};
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            up_q       <= up_d;
            down_q     <= down_d;
            door_q     <= (state_d == ST_DOOR_OPEN);
            busy_q     <= (state_d != ST_IDLE);
            fault_q    <= (state_d == ST_FAULT);
            target_q   <= target_d;
            door_cnt_q <= door_cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    assign up        = up_q;
    assign down      = down_q;
    assign door_open = door_q;
    assign pending   = pending_s;
    assign dir       = dir_q;
    assign busy      = busy_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler: a car model answers step pulses,
// and a SCAN reference model predicts stop order, step counts and direction.
module tb_elevator_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [1:0] floor = 2'd0;
    logic       up, down, door_open, dir, busy, fault;
    logic [3:0] pending;

    int checks = 0;
    int failures = 0;

    bit         ignore_steps = 1'b0;
    int         tele_seq = 0;
    int         seen_seq = 0;
    logic [1:0] tele_val = 2'd0;

    int   up_cnt = 0;
    int   down_cnt = 0;
    int   both_cnt = 0;
    int   door_run = 0;
    int   stops[$];
    int   door_lens[$];
    logic door_prev = 1'b0;

    elevator_scheduler #(
        .NUM_FLOORS(4), .FLOOR_W(2), .DOOR_CYCLES(4), .MOVE_TIMEOUT(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .floor(floor),
        .up(up), .down(down), .door_open(door_open), .pending(pending),
        .dir(dir), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    // Car model: one cycle after a step pulse the floor moves by one.
    always @(negedge clk) begin
        if (tele_seq != seen_seq) begin
            floor = tele_val;
            seen_seq = tele_seq;
        end else if ((up === 1'b1 || down === 1'b1) && !ignore_steps) begin
            automatic logic step_up = up;
            @(posedge clk);
            #1;
            floor = step_up ? floor + 2'd1 : floor - 2'd1;
        end
    end

    // Observer: pulse counts, stop order and door-open run lengths.
    always @(negedge clk) begin
        if (up === 1'b1) up_cnt++;
        if (down === 1'b1) down_cnt++;
        if (up === 1'b1 && down === 1'b1) both_cnt++;
        if (door_open === 1'b1 && door_prev !== 1'b1) stops.push_back(int'(floor));
        if (door_open === 1'b1) door_run++;
        else if (door_run > 0) begin
            door_lens.push_back(door_run);
            door_run = 0;
        end
        door_prev = door_open;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic teleport(input logic [1:0] v);
        tele_val = v;
        tele_seq++;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_req(input logic [3:0] m);
        req = m;
        @(negedge clk);
        req = 4'b0000;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int quiet;
        quiet = 0;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (busy === 1'b0) quiet++;
            else quiet = 0;
            if (quiet >= 3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int u0;
        reset_n = 1'b0;
        req = 4'b0000;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({up, down, door_open, busy, fault} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_outputs: got up/down/door/busy/fault=%b expected 00000", {up, down, door_open, busy, fault});
        end
        checks++;
        if (pending !== 4'b0000) begin failures++; $display("FAIL reset_pending: got %b expected 0000", pending); end
        checks++;
        if (dir !== 1'b1) begin failures++; $display("FAIL reset_dir: got %b expected 1", dir); end
        u0 = up_cnt + down_cnt;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || (up_cnt + down_cnt) != u0) begin
            failures++;
            $display("FAIL reset_stays_idle: busy=%b pulses=%0d expected busy=0 pulses=0", busy, up_cnt + down_cnt - u0);
        end
    endtask

    task automatic test_single_call();
        int u0, d0, s0;
        bit ok;
        u0 = up_cnt; d0 = down_cnt; s0 = stops.size();
        pulse_req(4'b1000);
        checks++;
        if (pending !== 4'b1000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL call_latch: pending=%b busy=%b expected pending=1000 busy=0", pending, busy);
        end
        @(negedge clk);
        checks++;
        if (up !== 1'b1 || down !== 1'b0) begin failures++; $display("FAIL call_first_up: up=%b down=%b expected 1/0", up, down); end
        wait_idle(300, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL call_idle_timeout: busy=%b expected 0", busy); end
        checks++;
        if (up_cnt - u0 != 3 || down_cnt - d0 != 0) begin
            failures++;
            $display("FAIL call_steps: up=%0d down=%0d expected 3/0", up_cnt - u0, down_cnt - d0);
        end
        checks++;
        if (stops.size() != s0 + 1 || stops[stops.size()-1] != 3) begin
            failures++;
            $display("FAIL call_stop: stops added=%0d expected one stop at floor 3", stops.size() - s0);
        end
        checks++;
        if (door_lens.size() == 0 || door_lens[door_lens.size()-1] != 4) begin
            failures++;
            $display("FAIL call_door_len: got %0d expected 4", door_lens.size() ? door_lens[door_lens.size()-1] : -1);
        end
        checks++;
        if (pending !== 4'b0000 || dir !== 1'b1) begin
            failures++;
            $display("FAIL call_final: pending=%b dir=%b expected 0000/1", pending, dir);
        end
    endtask

    task automatic test_scan_order();
        int u0, d0, s0;
        bit ok;
        teleport(2'd1);
        u0 = up_cnt; d0 = down_cnt; s0 = stops.size();
        pulse_req(4'b1001);
        @(negedge clk);
        checks++;
        if (dir !== 1'b1 || up !== 1'b1) begin failures++; $display("FAIL scan_start: dir=%b up=%b expected 1/1", dir, up); end
        wait_idle(400, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL scan_idle_timeout: busy=%b expected 0", busy); end
        checks++;
        if (stops.size() != s0 + 2 || stops[s0] != 3 || stops[s0+1] != 0) begin
            failures++;
            $display("FAIL scan_order: added=%0d expected stops 3 then 0", stops.size() - s0);
        end
        checks++;
        if (up_cnt - u0 != 2 || down_cnt - d0 != 3 || dir !== 1'b0) begin
            failures++;
            $display("FAIL scan_steps: up=%0d down=%0d dir=%b expected 2/3/0", up_cnt - u0, down_cnt - d0, dir);
        end
    endtask

    task automatic test_door_restart();
        int u0;
        bit found;
        bit ok;
        teleport(2'd2);
        u0 = up_cnt + down_cnt;
        pulse_req(4'b0100);
        found = 1'b0;
        for (int c = 0; c < 2 && !found; c++) begin
            @(negedge clk);
            if (door_open === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL door_latency: door_open=%b expected 1 within 2 cycles", door_open); end
        // Door cycle 1 observed; move into cycle 3 and call the same floor again.
        repeat (2) @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        checks++;
        if (pending !== 4'b0000 || door_open !== 1'b1) begin
            failures++;
            $display("FAIL door_no_latch: pending=%b door=%b expected 0000/1", pending, door_open);
        end
        wait_idle(100, ok);
        checks++;
        if (!ok || door_lens.size() == 0 || door_lens[door_lens.size()-1] != 7) begin
            failures++;
            $display("FAIL door_restart_len: got %0d expected 7", door_lens.size() ? door_lens[door_lens.size()-1] : -1);
        end
        checks++;
        if (up_cnt + down_cnt != u0) begin failures++; $display("FAIL door_no_move: pulses=%0d expected 0", up_cnt + down_cnt - u0); end
    endtask

    task automatic test_random_scan();
        int m_floor;
        logic m_dir;
        teleport(2'd0);
        do_reset();
        m_floor = 0;
        m_dir = 1'b1;
        for (int it = 0; it < 14; it++) begin
            logic [3:0] mask;
            int here_q[$], ups[$], downs[$], order[$];
            int exp_up, exp_down, cur, u0, d0, s0;
            bit ok;
            mask = 4'($urandom_range(1, 15));
            if (mask[m_floor]) here_q.push_back(m_floor);
            for (int i = m_floor + 1; i < 4; i++) if (mask[i]) ups.push_back(i);
            for (int i = m_floor - 1; i >= 0; i--) if (mask[i]) downs.push_back(i);
            order = here_q;
            if (m_dir) begin
                order = {order, ups, downs};
            end else begin
                order = {order, downs, ups};
            end
            exp_up = 0; exp_down = 0; cur = m_floor;
            foreach (order[k]) begin
                if (order[k] > cur) exp_up += order[k] - cur;
                else exp_down += cur - order[k];
                cur = order[k];
            end
            u0 = up_cnt; d0 = down_cnt; s0 = stops.size();
            pulse_req(mask);
            wait_idle(500, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL rand_idle_timeout: iter=%0d mask=%b", it, mask); end
            checks++;
            if (stops.size() - s0 != order.size()) begin
                failures++;
                $display("FAIL rand_stop_count: iter=%0d mask=%b got %0d expected %0d", it, mask, stops.size() - s0, order.size());
            end else begin
                foreach (order[k]) begin
                    checks++;
                    if (stops[s0+k] != order[k]) begin
                        failures++;
                        $display("FAIL rand_stop: iter=%0d idx=%0d got floor %0d expected %0d", it, k, stops[s0+k], order[k]);
                    end
                end
            end
            checks++;
            if (up_cnt - u0 != exp_up || down_cnt - d0 != exp_down) begin
                failures++;
                $display("FAIL rand_steps: iter=%0d got up=%0d down=%0d expected %0d/%0d", it, up_cnt - u0, down_cnt - d0, exp_up, exp_down);
            end
            if (m_dir) m_dir = (downs.size() != 0) ? 1'b0 : 1'b1;
            else       m_dir = (ups.size() != 0) ? 1'b1 : 1'b0;
            m_floor = cur;
            checks++;
            if (dir !== m_dir || pending !== 4'b0000) begin
                failures++;
                $display("FAIL rand_final: iter=%0d dir=%b pending=%b expected dir=%b pending=0000", it, dir, pending, m_dir);
            end
        end
        checks++;
        if (both_cnt != 0) begin failures++; $display("FAIL up_down_overlap: got %0d cycles expected 0", both_cnt); end
    endtask

    task automatic test_fault();
        int p0;
        teleport(2'd0);
        do_reset();
        ignore_steps = 1'b1;
        pulse_req(4'b0010);
        @(negedge clk);
        checks++;
        if (up !== 1'b1) begin failures++; $display("FAIL fault_up: up=%b expected 1", up); end
        repeat (8) @(negedge clk);
        checks++;
        if (fault !== 1'b0) begin failures++; $display("FAIL fault_early: fault=%b expected 0 after 7 wait cycles", fault); end
        @(negedge clk);
        checks++;
        if (fault !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL fault_set: fault=%b busy=%b expected 1/1", fault, busy); end
        p0 = up_cnt + down_cnt;
        repeat (10) @(negedge clk);
        checks++;
        if (up_cnt + down_cnt != p0 || fault !== 1'b1 || door_open !== 1'b0) begin
            failures++;
            $display("FAIL fault_sticky: pulses=%0d fault=%b door=%b expected 0/1/0", up_cnt + down_cnt - p0, fault, door_open);
        end
        pulse_req(4'b0100);
        checks++;
        if (pending !== 4'b0110) begin failures++; $display("FAIL fault_pending: got %b expected 0110", pending); end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (fault !== 1'b0 || pending !== 4'b0000) begin
            failures++;
            $display("FAIL fault_reset: fault=%b pending=%b expected 0/0000", fault, pending);
        end
        reset_n = 1'b1;
        ignore_steps = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midmove();
        int p0;
        teleport(2'd0);
        pulse_req(4'b1000);
        @(negedge clk);
        checks++;
        if (up !== 1'b1) begin failures++; $display("FAIL midreset_up: up=%b expected 1", up); end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (up !== 1'b0 || pending !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear: up=%b pending=%b busy=%b expected 0/0000/0", up, pending, busy);
        end
        reset_n = 1'b1;
        p0 = up_cnt + down_cnt;
        repeat (20) @(negedge clk);
        checks++;
        if (up_cnt + down_cnt != p0 || busy !== 1'b0 || door_open !== 1'b0) begin
            failures++;
            $display("FAIL midreset_quiet: pulses=%0d busy=%b door=%b expected 0/0/0", up_cnt + down_cnt - p0, busy, door_open);
        end
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_scan_order();
        test_door_restart();
        test_random_scan();
        test_fault();
        test_reset_midmove();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
